// File: rtl/ysyx_22041211_wbu_pkg.sv
// Shared write-back definitions: FSM encodings and fixed field widths.
package ysyx_22041211_wbu_pkg;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'b00,
        WB_WRITE = 2'b01,
        WB_DONE  = 2'b10
    } wb_state_e;

    localparam int CSR_ADDR_LEN = 12;
    localparam int GPR_ZERO     = 0;

endpackage

// File: rtl/ysyx_22041211_wbu_if.sv
// LSU->WBU payload handshake and WBU->IFU retire handshake.
interface ysyx_22041211_wbu_if
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
);
    logic                    lsu_valid_i;
    logic                    wb_ready_o;
    logic                    wd_i;
    logic [REG_ADDR_LEN-1:0] wreg_i;
    logic [DATA_LEN-1:0]     wdata_i;
    logic                    csr_wen_i;
    logic [CSR_ADDR_LEN-1:0] csr_addr_i;
    logic [DATA_LEN-1:0]     csr_wdata_i;
    logic                    wb_valid_o;
    logic                    ifu_ready_i;

    modport master (
        output lsu_valid_i, wd_i, wreg_i, wdata_i,
        output csr_wen_i, csr_addr_i, csr_wdata_i,
        output ifu_ready_i,
        input  wb_ready_o, wb_valid_o
    );

    modport slave (
        input  lsu_valid_i, wd_i, wreg_i, wdata_i,
        input  csr_wen_i, csr_addr_i, csr_wdata_i,
        input  ifu_ready_i,
        output wb_ready_o, wb_valid_o
    );

endinterface

// File: rtl/ysyx_22041211_wbu_regfile.sv
// Architectural GPR array: one gated write port, two combinational reads.
module ysyx_22041211_wbu_regfile #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [REG_ADDR_LEN-1:0] waddr,
    input  logic [DATA_LEN-1:0]     wdata,
    input  logic [REG_ADDR_LEN-1:0] raddr1,
    input  logic [REG_ADDR_LEN-1:0] raddr2,
    output logic [DATA_LEN-1:0]     rdata1,
    output logic [DATA_LEN-1:0]     rdata2
);
    localparam int NREG = 1 << REG_ADDR_LEN;

    logic [DATA_LEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // x0 is hardwired regardless of array contents
    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// Write-back unit: commits GPR result, forwards CSR write, counts retirement.
module ysyx_22041211_wbu
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22041211_wbu_if.slave      wb,
    input  logic [REG_ADDR_LEN-1:0] raddr1_i,
    input  logic [REG_ADDR_LEN-1:0] raddr2_i,
    output logic [DATA_LEN-1:0]     rdata1_o,
    output logic [DATA_LEN-1:0]     rdata2_o,
    output logic                    csr_wen_o,
    output logic [CSR_ADDR_LEN-1:0] csr_addr_o,
    output logic [DATA_LEN-1:0]     csr_wdata_o,
    output logic [63:0]             instret_o
);
    wb_state_e state_q, state_d;

    logic                    wd_q;
    logic [REG_ADDR_LEN-1:0] wreg_q;
    logic [DATA_LEN-1:0]     wdata_q;
    logic                    csr_wen_q;
    logic [CSR_ADDR_LEN-1:0] csr_addr_q;
    logic [DATA_LEN-1:0]     csr_wdata_q;
    logic [63:0]             instret_q;

    logic accept;
    logic gpr_we;

    assign accept = (state_q == WB_IDLE) && wb.lsu_valid_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE:  if (wb.lsu_valid_i) state_d = WB_WRITE;
            WB_WRITE: state_d = WB_DONE;
            WB_DONE:  if (wb.ifu_ready_i) state_d = WB_IDLE;
            default:  state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        wb.wb_ready_o = 1'b0;
        wb.wb_valid_o = 1'b0;
        csr_wen_o     = 1'b0;
        gpr_we        = 1'b0;
        unique case (state_q)
            WB_IDLE:  wb.wb_ready_o = 1'b1;
            WB_WRITE: begin
                csr_wen_o = csr_wen_q;
                gpr_we    = wd_q && (wreg_q != REG_ADDR_LEN'(GPR_ZERO));
            end
            WB_DONE:  wb.wb_valid_o = 1'b1;
            default:  ;
        endcase
    end

    // Payload only captured on the accepting edge, so CSR outputs hold between writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            csr_wen_q   <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
        end else if (accept) begin
            wd_q        <= wb.wd_i;
            wreg_q      <= wb.wreg_i;
            wdata_q     <= wb.wdata_i;
            csr_wen_q   <= wb.csr_wen_i;
            csr_addr_q  <= wb.csr_addr_i;
            csr_wdata_q <= wb.csr_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (state_q == WB_WRITE) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign csr_addr_o  = csr_addr_q;
    assign csr_wdata_o = csr_wdata_q;
    assign instret_o   = instret_q;

    ysyx_22041211_wbu_regfile #(
        .DATA_LEN     (DATA_LEN),
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (gpr_we),
        .waddr  (wreg_q),
        .wdata  (wdata_q),
        .raddr1 (raddr1_i),
        .raddr2 (raddr2_i),
        .rdata1 (rdata1_o),
        .rdata2 (rdata2_o)
    );

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Scoreboard bench for the write-back unit.
module tb_ysyx_22041211_wbu;
    import ysyx_22041211_wbu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22041211_wbu_if #(.DATA_LEN(32), .REG_ADDR_LEN(5)) wbi ();

    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [63:0] instret;

    ysyx_22041211_wbu #(.DATA_LEN(32), .REG_ADDR_LEN(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wbi.slave),
        .raddr1_i    (raddr1),
        .raddr2_i    (raddr2),
        .rdata1_o    (rdata1),
        .rdata2_o    (rdata2),
        .csr_wen_o   (csr_wen),
        .csr_addr_o  (csr_addr),
        .csr_wdata_o (csr_wdata),
        .instret_o   (instret)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [63:0] ir;
    } ret_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } csr_t;

    ret_t        ret_q[$];
    csr_t        csr_q[$];
    logic [63:0] icnt;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: retire notifications and CSR strobes are checked against queues
    initial begin : mon
        logic vprev;
        logic cprev;
        ret_t r;
        csr_t c;
        vprev = 1'b0;
        cprev = 1'b0;
        raddr1 = '0;
        forever begin
            @(negedge clk);
            if (csr_wen) begin
                chk("csr_pulse_len", cprev, 1'b0);
                chk("csr_expected", csr_q.size() != 0, 1'b1);
                if (csr_q.size() != 0) begin
                    c = csr_q.pop_front();
                    chk("csr_addr", csr_addr, c.a);
                    chk("csr_wdata", csr_wdata, c.d);
                end
            end
            cprev = csr_wen;
            if (wbi.wb_valid_o && !vprev) begin
                chk("ret_expected", ret_q.size() != 0, 1'b1);
                if (ret_q.size() != 0) begin
                    r = ret_q.pop_front();
                    raddr1 = r.a;
                    #1;
                    chk("ret_rdata", rdata1, r.d);
                    chk("ret_instret", instret, r.ir);
                end
            end
            vprev = wbi.wb_valid_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wbi.wb_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!wbi.wb_ready_o) chk("ready_timeout", wbi.wb_ready_o, 1'b1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!wbi.wb_valid_o && n < 50) begin
            tick();
            n++;
        end
        if (!wbi.wb_valid_o) chk("valid_timeout", wbi.wb_valid_o, 1'b1);
    endtask

    task automatic send(input logic wd, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic cw,
                        input logic [11:0] ca, input logic [31:0] cd,
                        input logic [4:0] ea, input logic [31:0] ed,
                        input logic push);
        wait_ready();
        @(negedge clk);
        wbi.lsu_valid_i = 1'b1;
        wbi.wd_i        = wd;
        wbi.wreg_i      = wreg;
        wbi.wdata_i     = wdata;
        wbi.csr_wen_i   = cw;
        wbi.csr_addr_i  = ca;
        wbi.csr_wdata_i = cd;
        if (push) begin
            icnt = icnt + 64'd1;
            ret_q.push_back('{ea, ed, icnt});
            if (cw) csr_q.push_back('{ca, cd});
        end
        tick();
        wbi.lsu_valid_i = 1'b0;
    endtask

    initial begin
        wbi.lsu_valid_i = 1'b0;
        wbi.wd_i        = 1'b0;
        wbi.wreg_i      = '0;
        wbi.wdata_i     = '0;
        wbi.csr_wen_i   = 1'b0;
        wbi.csr_addr_i  = '0;
        wbi.csr_wdata_i = '0;
        wbi.ifu_ready_i = 1'b1;
        raddr2 = 5'd5;
        icnt   = '0;

        repeat (2) tick();
        chk("rst_ready", wbi.wb_ready_o, 1'b1);
        chk("rst_valid", wbi.wb_valid_o, 1'b0);
        chk("rst_csr_wen", csr_wen, 1'b0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_x5", rdata2, 32'd0);
        rst = 1'b1;
        tick();

        // Basic GPR write; old value visible during the write cycle
        send(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'h0, 32'h0,
             5'd5, 32'hDEADBEEF, 1'b1);
        raddr2 = 5'd5;
        #1;
        chk("no_bypass", rdata2, 32'd0);
        tick();
        chk("t1_valid", wbi.wb_valid_o, 1'b1);
        chk("t1_x5", rdata2, 32'hDEADBEEF);
        tick();
        chk("t1_valid_drop", wbi.wb_valid_o, 1'b0);
        chk("t1_ready", wbi.wb_ready_o, 1'b1);

        // x0 write dropped
        send(1'b1, 5'd0, 32'h12345678, 1'b0, 12'h0, 32'h0,
             5'd0, 32'h0, 1'b1);

        // CSR-only instruction; x5 must keep its value
        send(1'b0, 5'd5, 32'h00000BAD, 1'b1, 12'h341, 32'h80000004,
             5'd5, 32'hDEADBEEF, 1'b1);

        // IFU back-pressure with stray payloads
        wait_ready();
        wbi.ifu_ready_i = 1'b0;
        send(1'b1, 5'd3, 32'h00000011, 1'b0, 12'h0, 32'h0,
             5'd3, 32'h00000011, 1'b1);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wbi.lsu_valid_i = 1'b1;
            wbi.wd_i        = 1'b1;
            wbi.wreg_i      = 5'd3;
            wbi.wdata_i     = 32'h00000099;
            tick();
            chk("hold_valid", wbi.wb_valid_o, 1'b1);
            chk("hold_ready", wbi.wb_ready_o, 1'b0);
        end
        wbi.lsu_valid_i = 1'b0;
        wbi.ifu_ready_i = 1'b1;
        tick();
        chk("hold_release", wbi.wb_ready_o, 1'b1);
        tick();
        chk("hold_idle", wbi.wb_ready_o, 1'b1);
        raddr2 = 5'd3;
        #1;
        chk("hold_x3", rdata2, 32'h00000011);
        chk("hold_instret", instret, icnt);

        // Reset while a write to x7 is pending
        send(1'b1, 5'd7, 32'h0000CAFE, 1'b0, 12'h0, 32'h0,
             5'd7, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        icnt = '0;
        chk("rw_ready", wbi.wb_ready_o, 1'b1);
        chk("rw_valid", wbi.wb_valid_o, 1'b0);
        chk("rw_instret", instret, 64'd0);
        raddr2 = 5'd7;
        #1;
        chk("rw_x7", rdata2, 32'd0);
        raddr2 = 5'd5;
        #1;
        chk("rw_x5_cleared", rdata2, 32'd0);

        // Reset coincident with a payload: reset wins
        @(negedge clk);
        rst = 1'b0;
        wbi.lsu_valid_i = 1'b1;
        wbi.wd_i        = 1'b1;
        wbi.wreg_i      = 5'd9;
        wbi.wdata_i     = 32'h00000009;
        tick();
        rst = 1'b1;
        wbi.lsu_valid_i = 1'b0;
        tick();
        chk("rl_ready", wbi.wb_ready_o, 1'b1);
        chk("rl_instret", instret, 64'd0);
        raddr2 = 5'd9;
        #1;
        chk("rl_x9", rdata2, 32'd0);

        // Counter wrap via backdoor preset
        @(negedge clk);
        dut.instret_q = '1;
        icnt = '1;
        send(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 12'h0, 32'h0,
             5'd4, 32'hA5A5A5A5, 1'b1);

        wait_ready();
        repeat (3) tick();
        chk("ret_q_drained", ret_q.size(), 0);
        chk("csr_q_drained", csr_q.size(), 0);
        chk("end_instret", instret, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
